// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences one single-ported memory between CPU and loader ports,
// one locked transaction at a time, round-robin on ties.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              gnt_ldr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  state_t state;
  logic last_gnt, we_q, pick_ldr;
  logic [3:0] cnt;
  // loader wins if alone, or on a tie when the CPU took the previous grant
  assign pick_ldr = ldr_req && (!cpu_req || !last_gnt);
  assign busy = state != IDLE;
  assign mem_en = state == ACCESS;
  assign mem_we = state == ACCESS && we_q;
  assign cpu_ready = state == RESP && !gnt_ldr;
  assign ldr_ready = state == RESP && gnt_ldr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      gnt_ldr <= 1'b0;
      we_q <= 1'b0;
      cnt <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (cpu_req || ldr_req) begin
            last_gnt <= pick_ldr;
            gnt_ldr <= pick_ldr;
            we_q <= pick_ldr ? ldr_we : cpu_we;
            mem_addr <= pick_ldr ? ldr_addr : cpu_addr;
            mem_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
            state <= ACCESS;
          end
        ACCESS: begin
          cnt <= LAT;
          state <= we_q ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rdata <= mem_rdata;
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, contention/reset sequences and a random
// two-requester run checked against a transaction-level memory model.
module tb_mem_port_arbiter;
  logic clk = 0, reset = 1, mem_init = 1;
  always #5 clk = ~clk;
  logic cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
  logic cpu_ready, ldr_ready, busy, gnt_ldr, mem_en, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic c1_req = 0;
  logic [31:0] c1_addr = 0;
  logic c1_ready, l1_ready, b1, g1, e1, w1;
  logic [31:0] c1_rdata, m1_addr, m1_wdata, m1_rdata;
  int total = 0, bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ready(ldr_ready),
    .rdata(rdata), .busy(busy), .gnt_ldr(gnt_ldr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(32'h0), .cpu_ready(c1_ready),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0), .ldr_ready(l1_ready),
    .rdata(c1_rdata), .busy(b1), .gnt_ldr(g1), .mem_en(e1), .mem_we(w1),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata));

  always @(posedge clk)
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + i;
    end else if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];
  assign m1_rdata = {8'hA5, m1_addr[23:0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    cpu_req = 0;
    ldr_req = 0;
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
  endtask

  typedef struct {
    logic ldr;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int lat;
    logic [31:0] rd;
  } vec_t;
  vec_t vt[6];

  initial begin
    int n, idle, r;
    logic other, exp_l;
    logic out[2], we_r[2];
    int wt[2], idx[2];
    logic [31:0] wd[2];
    localparam int BOUND = 2 * (2 + 3);
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + i;
    vt[0] = '{1'b0, 1'b0, 32'h040, 32'h0, 4, 32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b1, 32'h100, 32'h12345678, 2, 32'hDEADBEEF};
    vt[2] = '{1'b0, 1'b0, 32'h100, 32'h0, 4, 32'h12345678};
    vt[3] = '{1'b0, 1'b1, 32'h044, 32'hCAFEF00D, 2, 32'h12345678};
    vt[4] = '{1'b1, 1'b0, 32'h044, 32'h0, 4, 32'hCAFEF00D};
    vt[5] = '{1'b1, 1'b0, 32'h3FC, 32'h0, 4, 32'h100000FF};
    do_reset;
    mem_init = 0;
    chk1("rst_busy", busy, 0);
    chk1("rst_mem_en", mem_en, 0);
    chk1("rst_mem_we", mem_we, 0);
    chk1("rst_gnt", gnt_ldr, 0);
    chk1("rst_ready", cpu_ready | ldr_ready, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);

    foreach (vt[k]) begin
      if (vt[k].ldr) begin
        ldr_req = 1; ldr_we = vt[k].we; ldr_addr = vt[k].addr; ldr_wdata = vt[k].wdata;
      end else begin
        cpu_req = 1; cpu_we = vt[k].we; cpu_addr = vt[k].addr; cpu_wdata = vt[k].wdata;
      end
      tick;
      chk1("vec_en", mem_en, 1);
      chk1("vec_we", mem_we, vt[k].we);
      chk("vec_addr", mem_addr, vt[k].addr);
      chk("vec_wdata", mem_wdata, vt[k].wdata);
      chk1("vec_gnt", gnt_ldr, vt[k].ldr);
      n = 1;
      other = 0;
      while (!(vt[k].ldr ? ldr_ready : cpu_ready) && n < 20) begin
        other |= vt[k].ldr ? cpu_ready : ldr_ready;
        tick;
        n++;
      end
      other |= vt[k].ldr ? cpu_ready : ldr_ready;
      chk("vec_lat", n, vt[k].lat);
      chk("vec_rdata", rdata, vt[k].rd);
      chk1("vec_other_ready", other, 0);
      tick;
      cpu_req = 0;
      ldr_req = 0;
    end

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    tick;
    tick;
    chk1("rstw_busy_pre", busy, 1);
    #2 reset = 1;
    #1;
    chk1("rstw_busy", busy, 0);
    chk1("rstw_mem_en", mem_en, 0);
    chk1("rstw_ready", cpu_ready, 0);
    chk1("rstw_gnt", gnt_ldr, 0);
    chk("rstw_rdata", rdata, 0);
    chk("rstw_addr", mem_addr, 0);
    @(posedge clk);
    #1 reset = 0;
    chk1("rstw_no_ready", cpu_ready, 0);
    tick;
    chk1("rstw_access", mem_en, 1);
    n = 1;
    while (!cpu_ready && n < 20) begin
      tick;
      n++;
    end
    chk("rstw_lat", n, 4);
    chk("rstw_rdata2", rdata, 32'hDEADBEEF);
    tick;
    cpu_req = 0;

    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h100;
    n = 0;
    idle = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      tick;
      if (!busy) idle++;
      if (cpu_ready | ldr_ready) begin
        exp_l = n[0];
        chk1("cont_ldr_ready", ldr_ready, exp_l);
        chk1("cont_cpu_ready", cpu_ready, !exp_l);
        chk1("cont_gnt", gnt_ldr, exp_l);
        chk("cont_rdata", rdata, exp_l ? 32'h12345678 : 32'hDEADBEEF);
        if (n > 0) chk("cont_idle", idle, 1);
        idle = 0;
        n++;
      end
    end
    chk("cont_count", n, 6);
    cpu_req = 0;
    ldr_req = 0;
    tick;

    c1_req = 1;
    c1_addr = 0;
    r = 0;
    for (int c = 1; c <= 12 && r < 2; c++) begin
      tick;
      if (c == 4) c1_addr = 32'h4;
      if (c1_ready) begin
        chk("lat1_cycle", c, r > 0 ? 7 : 3);
        chk("lat1_rdata", c1_rdata, r > 0 ? 32'hA5000004 : 32'hA5000000);
        r++;
      end
    end
    chk("lat1_count", r, 2);
    c1_req = 0;

    for (int p = 0; p < 2; p++) begin
      out[p] = 0; wt[p] = 0; we_r[p] = 0; idx[p] = 0; wd[p] = 0;
    end
    for (int c = 0; c < 700; c++) begin
      tick;
      for (int p = 0; p < 2; p++) begin
        if (out[p]) wt[p]++;
        if (p == 1 ? ldr_ready : cpu_ready) begin
          chk1("rnd_owner", out[p], 1);
          if (out[p]) begin
            chk1("rnd_latency_bound", wt[p] <= BOUND, 1);
            if (we_r[p]) ref_mem[idx[p]] = wd[p];
            else chk("rnd_rdata", rdata, ref_mem[idx[p]]);
          end
          out[p] = 0;
        end else if (out[p] && wt[p] > 2 * BOUND) begin
          chk("rnd_timeout", wt[p], 0);
          out[p] = 0;
        end
        if (!out[p] && c < 640 && $urandom_range(0, 1) == 0) begin
          out[p] = 1;
          wt[p] = 0;
          we_r[p] = 1'($urandom_range(0, 1));
          idx[p] = (p == 1 ? 128 : 32) + int'($urandom_range(0, 15));
          wd[p] = $urandom;
        end
      end
      cpu_req = out[0]; cpu_we = we_r[0]; cpu_addr = 32'(idx[0] * 4); cpu_wdata = wd[0];
      ldr_req = out[1]; ldr_we = we_r[1]; ldr_addr = 32'(idx[1] * 4); ldr_wdata = wd[1];
    end
    chk1("rnd_drain", out[0] | out[1], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
